// File: rtl/axi_stream_fork_n.sv
// axi_stream_fork_n: N-way AXI-Stream fork. One wide input beat is split into
// N_CH slices; a per-beat mask selects which channels receive their slice.
//   REG_OUT=0 : combinational fork. A per-channel done flag records channels
//               that already took the current beat so that each one fires once.
//   REG_OUT=1 : 2-entry FIFO per channel. a_ready depends only on registered
//               counts and a_mask, so no path runs from m_ready to a_ready.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   a_valid/a_data/a_mask   input beat, with slice i = a_data[i*DATA_WD +: DATA_WD]
//   a_ready                 input beat accepted when a_valid & a_ready
//   m_valid/m_data/m_ready  per-channel outputs, sliced the same way as a_data
//   beat_cnt                accepted input beats, wrapping
//   drop_cnt                accepted beats with a_mask == 0, wrapping

// Logic for one output channel. ch_ok is this channel's vote toward a_ready.
module axi_stream_fork_ch #(
  parameter int DATA_WD = 8,
  parameter bit REG_OUT = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a_valid,
  input  logic               a_ready,
  input  logic               a_sel,
  input  logic [DATA_WD-1:0] a_slice,
  output logic               m_valid,
  output logic [DATA_WD-1:0] m_data,
  input  logic               m_ready,
  output logic               ch_ok
);
  logic a_fire, ch_fire;
  assign a_fire  = a_valid & a_ready;
  assign ch_fire = m_valid & m_ready;

  generate
    if (REG_OUT == 1'b0) begin : g_comb
      logic done;
      // Accepting the beat re-arms the channel. This takes priority over a
      // same-cycle delivery, because that delivery belongs to the beat now leaving.
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)       done <= 1'b0;
        else if (a_fire)  done <= 1'b0;
        else if (ch_fire) done <= 1'b1;

      assign m_valid = a_valid & a_sel & ~done;
      assign m_data  = a_slice;
      assign ch_ok   = ~a_sel | done | m_ready;
    end else begin : g_buf
      logic [1:0][DATA_WD-1:0] mem;
      logic                    wp, rp;
      logic [1:0]              cnt;
      logic                    push, pop;

      assign push = a_fire & a_sel;
      assign pop  = ch_fire;

      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          mem <= '0;
          wp  <= 1'b0;
          rp  <= 1'b0;
          cnt <= 2'd0;
        end else begin
          if (push) begin
            mem[wp] <= a_slice;
            wp      <= ~wp;
          end
          if (pop) rp <= ~rp;
          case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: ;
          endcase
        end

      assign m_valid = (cnt != 2'd0);
      assign m_data  = mem[rp];
      assign ch_ok   = ~a_sel | (cnt != 2'd2);
    end
  endgenerate
endmodule

module axi_stream_fork_n #(
  parameter int N_CH    = 4,
  parameter int DATA_WD = 8,
  parameter bit REG_OUT = 1'b0,
  parameter int CNT_WD  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_valid,
  input  logic [N_CH*DATA_WD-1:0] a_data,
  input  logic [N_CH-1:0]         a_mask,
  output logic                    a_ready,
  output logic [N_CH-1:0]         m_valid,
  output logic [N_CH*DATA_WD-1:0] m_data,
  input  logic [N_CH-1:0]         m_ready,
  output logic [CNT_WD-1:0]       beat_cnt,
  output logic [CNT_WD-1:0]       drop_cnt
);
  logic [N_CH-1:0]              ch_ok;
  logic [N_CH-1:0][DATA_WD-1:0] a_slices, m_slices;
  logic                         a_fire;

  assign a_slices = a_data;
  assign m_data   = m_slices;
  // An all-zero mask makes every vote 1, so those beats are accepted at once.
  assign a_ready  = &ch_ok;
  assign a_fire   = a_valid & a_ready;

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      axi_stream_fork_ch #(.DATA_WD(DATA_WD), .REG_OUT(REG_OUT)) u_ch (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_sel   (a_mask[i]),
        .a_slice (a_slices[i]),
        .m_valid (m_valid[i]),
        .m_data  (m_slices[i]),
        .m_ready (m_ready[i]),
        .ch_ok   (ch_ok[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      beat_cnt <= '0;
      drop_cnt <= '0;
    end else if (a_fire) begin
      beat_cnt <= beat_cnt + CNT_WD'(1);
      if (a_mask == '0) drop_cnt <= drop_cnt + CNT_WD'(1);
    end
endmodule

// File: tb/tb_axi_stream_fork_n.sv
// Bench for axi_stream_fork_n. u0 is unbuffered with a 4-bit counter so that
// wrap is reachable. u1 is buffered. A behavioural model tracks, per beat, the
// channels still owed a delivery (u0) and a queue of pending slices per
// channel (u1), and every cycle checks the model against both DUTs.
module tb_axi_stream_fork_n;
  localparam int N = 4, DW = 8;

  logic clk = 1'b0, rst_n;
  always #5 clk = ~clk;

  logic            av0, av1, ar0, ar1;
  logic [N*DW-1:0] ad0, ad1, md0, md1;
  logic [N-1:0]    am0, am1, mr0, mr1, mv0, mv1;
  logic [3:0]      bc0, dc0;
  logic [15:0]     bc1, dc1;

  axi_stream_fork_n #(.N_CH(N), .DATA_WD(DW), .REG_OUT(1'b0), .CNT_WD(4)) u0 (
    .clk(clk), .rst_n(rst_n), .a_valid(av0), .a_data(ad0), .a_mask(am0), .a_ready(ar0),
    .m_valid(mv0), .m_data(md0), .m_ready(mr0), .beat_cnt(bc0), .drop_cnt(dc0));
  axi_stream_fork_n #(.N_CH(N), .DATA_WD(DW), .REG_OUT(1'b1), .CNT_WD(16)) u1 (
    .clk(clk), .rst_n(rst_n), .a_valid(av1), .a_data(ad1), .a_mask(am1), .a_ready(ar1),
    .m_valid(mv1), .m_data(md1), .m_ready(mr1), .beat_cnt(bc1), .drop_cnt(dc1));

  int n_assert = 0, n_fail = 0;

  // model state
  logic [N-1:0] dlv0;                 // channels that already took u0's current beat
  logic [DW-1:0] exp0 [N][$];         // slices u0 owes each channel, in order
  logic [DW-1:0] got0 [N][$];         // slices u0 actually delivered
  logic [DW-1:0] q1   [N][$];         // slices pending inside u1, per channel
  int dl1 [N];
  int beats0, drops0, beats1, drops1;
  bit stall0, stall1, fire1_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    dlv0 = '0;
    beats0 = 0; drops0 = 0; beats1 = 0; drops1 = 0;
    for (int i = 0; i < N; i++) begin
      exp0[i].delete(); got0[i].delete(); q1[i].delete(); dl1[i] = 0;
    end
  endtask

  // One clock: check outputs at negedge, advance the model at posedge.
  task automatic step();
    logic [N-1:0] emv0, emv1, cf0, cf1, m0, m1;
    logic ear0, ear1, f0, f1;
    logic [N-1:0][DW-1:0] d0, d1, s0, s1;
    @(negedge clk);
    emv0 = (av0 ? am0 : '0) & ~dlv0;
    ear0 = 1'b1; ear1 = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (am0[i] && !dlv0[i] && !mr0[i]) ear0 = 1'b0;
      if (am1[i] && q1[i].size() >= 2)   ear1 = 1'b0;
      emv1[i] = (q1[i].size() != 0);
    end
    chk("u0_a_ready", ar0, ear0);
    chk("u0_m_valid", mv0, emv0);
    chk("u0_beat_cnt", bc0, beats0 % 16);
    chk("u0_drop_cnt", dc0, drops0 % 16);
    chk("u1_a_ready", ar1, ear1);
    chk("u1_m_valid", mv1, emv1);
    chk("u1_beat_cnt", bc1, beats1 % 65536);
    chk("u1_drop_cnt", dc1, drops1 % 65536);
    d0 = md0; d1 = md1; s0 = ad0; s1 = ad1; m0 = am0; m1 = am1;
    for (int i = 0; i < N; i++) begin
      if (emv0[i]) chk("u0_m_data", d0[i], s0[i]);
      if (emv1[i]) chk("u1_m_data", d1[i], q1[i][0]);
    end
    f0 = av0 & ar0; f1 = av1 & ar1;
    cf0 = mv0 & mr0; cf1 = mv1 & mr1;
    stall0 = av0 & ~ar0; stall1 = av1 & ~ar1; fire1_seen = f1;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (cf0[i]) got0[i].push_back(d0[i]);
      if (cf1[i]) begin
        if (q1[i].size() != 0) void'(q1[i].pop_front());
        dl1[i]++;
      end
    end
    if (f0) begin
      beats0++;
      if (m0 == '0) drops0++;
      for (int i = 0; i < N; i++) if (m0[i]) exp0[i].push_back(s0[i]);
      dlv0 = '0;
    end else dlv0 = dlv0 | cf0;
    if (f1) begin
      beats1++;
      if (m1 == '0) drops1++;
      for (int i = 0; i < N; i++) if (m1[i]) q1[i].push_back(s1[i]);
    end
    #1;
  endtask

  // Call only when u0 has no partially delivered beat.
  task automatic check_u0_log();
    for (int i = 0; i < N; i++) begin
      chk("u0_deliv_count", got0[i].size(), exp0[i].size());
      for (int k = 0; k < exp0[i].size() && k < got0[i].size(); k++)
        chk("u0_deliv_data", got0[i][k], exp0[i][k]);
      got0[i].delete(); exp0[i].delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int at_stall, stall_cnt, w;
    rst_n = 1'b0;
    av0 = 0; av1 = 0; ad0 = '0; ad1 = '0; am0 = '0; am1 = '0; mr0 = '0; mr1 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_u0_m_valid", mv0, 4'h0); chk("rst_u1_m_valid", mv1, 4'h0);
    chk("rst_u0_beat", bc0, 0); chk("rst_u0_drop", dc0, 0);
    chk("rst_u1_beat", bc1, 0); chk("rst_u1_drop", dc1, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // u0: full mask, everyone ready -> zero-latency split
    ad0 = 32'h44332211; am0 = 4'hF; mr0 = 4'hF; av0 = 1; step();
    av0 = 0; step();
    chk("u0_first_beat_cnt", bc0, 4'd1);

    // u0: mask 0101, ch2 stalled 3 cycles
    ad0 = 32'hAABBCCDD; am0 = 4'b0101; mr0 = 4'b0001; av0 = 1;
    repeat (3) step();
    mr0 = 4'b0101; step();
    av0 = 0; step();
    check_u0_log();

    // u0: zero mask for 3 cycles
    am0 = 4'h0; av0 = 1; repeat (3) step();
    av0 = 0; step();
    chk("u0_drop_3", dc0, 4'd3);

    // u0: 12 more beats -> 17 total, 4-bit counter wraps to 1
    am0 = 4'hF; mr0 = 4'hF; av0 = 1;
    for (int k = 0; k < 12; k++) begin ad0 = $urandom; step(); end
    av0 = 0; step();
    chk("u0_wrap", bc0, 4'd1);
    check_u0_log();

    // u1: 6 beats, ch3 stalled until 4 stall cycles have passed
    am1 = 4'hF; mr1 = 4'b0111; at_stall = -1; stall_cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      ad1 = {4{8'(k)}}; av1 = 1; w = 0;
      do begin
        step();
        if (!fire1_seen) begin
          w++; stall_cnt++;
          if (at_stall < 0) at_stall = beats1;
          if (stall_cnt == 4) mr1 = 4'hF;
        end
      end while (!fire1_seen && w < 20);
      if (!fire1_seen) chk("u1_fire_timeout", 0, 1);
    end
    av1 = 0; repeat (4) step();
    chk("u1_stall_point", at_stall, 2);
    for (int i = 0; i < N; i++) begin
      chk("u1_delivered", dl1[i], 6);
      chk("u1_empty", q1[i].size(), 0);
    end

    // random traffic on both, holding a stalled beat stable
    for (int c = 0; c < 400; c++) begin
      if (!stall0) begin av0 = 1'($urandom); am0 = 4'($urandom); ad0 = $urandom; end
      if (!stall1) begin av1 = 1'($urandom); am1 = 4'($urandom); ad1 = $urandom; end
      mr0 = ~4'($urandom & $urandom);
      mr1 = ~4'($urandom & $urandom);
      step();
    end
    av0 = 0; av1 = 0; mr0 = 4'hF; mr1 = 4'hF;
    repeat (4) step();
    check_u0_log();
    for (int i = 0; i < N; i++) chk("u1_rand_empty", q1[i].size(), 0);

    // reset mid-operation: u1 holds 2 entries, u0 has ch1 delivered
    am1 = 4'hF; mr1 = 4'h0; av1 = 1; ad1 = 32'h01020304; step();
    ad1 = 32'h05060708; step();
    av1 = 0;
    am0 = 4'b0110; mr0 = 4'b0010; ad0 = 32'h99887766; av0 = 1; step();
    chk("pre_rst_u1_valid", mv1, 4'hF);
    #1 rst_n = 1'b0; av0 = 0;
    model_reset();
    step();
    chk("rst_mid_u0_m_valid", mv0, 4'h0); chk("rst_mid_u1_m_valid", mv1, 4'h0);
    chk("rst_mid_u0_beat", bc0, 0); chk("rst_mid_u1_beat", bc1, 0);
    rst_n = 1'b1;
    am0 = 4'hF; mr0 = 4'hF; ad0 = 32'hDEADBEEF; av0 = 1;
    am1 = 4'hF; mr1 = 4'hF; ad1 = 32'hCAFEF00D; av1 = 1;
    step();
    av0 = 0; av1 = 0;
    repeat (2) step();
    check_u0_log();
    for (int i = 0; i < N; i++) chk("u1_post_rst_deliv", dl1[i], 1);
    chk("u1_post_rst_beat", bc1, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_stream_fork_n.md
Name: axi_stream_fork_n

Overview:
- Parametrised N-way AXI-Stream fork. Splits one wide input beat into N_CH per-channel slices.
- A per-beat destination mask selects which output channels receive the beat.
- Two build modes:
  - Low-latency mode: combinational, with per-channel delivered flags.
  - Registered mode: a 2-entry buffer per channel removes every ready-to-ready combinational path.
- Sits between a wide producer and independent downstream consumers. Each consumer may stall independently.

Parameters:
- N_CH, 4, number of output channels (≥2).
- DATA_WD, 8, width of each channel slice.
- REG_OUT, 0, 0 = unbuffered fork with delivered flags; 1 = 2-entry per-channel buffers.
- CNT_WD, 16, width of the accepted-beat counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- a_valid  input  1  input beat valid.
- a_data  input  N_CH*DATA_WD  slice i = a_data[i*DATA_WD +: DATA_WD] goes to channel i.
- a_mask  input  N_CH  bit i=1 means deliver slice i to channel i.
- a_ready  output  1  input beat accepted when a_valid & a_ready.
- m_valid  output  N_CH  per-channel valid.
- m_data  output  N_CH*DATA_WD  per-channel data, same slicing as a_data.
- m_ready  input  N_CH  per-channel ready.
- beat_cnt  output  CNT_WD  count of accepted input beats. Wraps modulo 2^CNT_WD.
- drop_cnt  output  CNT_WD  count of accepted beats with a_mask==0. Wraps.

Behaviour:
- Fire definitions: a_fire = a_valid & a_ready; ch_fire[i] = m_valid[i] & m_ready[i].
- Source obligation: a_data and a_mask are held stable while a_valid & !a_ready.
- Reset values:
  - m_valid = 0, beat_cnt = 0, drop_cnt = 0.
  - All delivered flags cleared; all buffer counts = 0.
  - a_ready is unconstrained in reset only as its combinational formula gives.
- Reset mid-operation: all in-flight beats and buffered entries are discarded. No output valid is held across reset.
- REG_OUT=0 (unbuffered):
  - done[i] register per channel.
  - m_valid[i] = a_valid & a_mask[i] & !done[i]. m_valid never depends on m_ready.
  - m_data[i] = slice i of a_data, passed through combinationally.
  - a_ready = AND over i of (!a_mask[i] | done[i] | m_ready[i]).
  - done[i] is set on ch_fire[i] when !a_fire. On a_fire, all done bits clear; a clear beats a same-cycle set.
  - Each channel sees exactly one fire per accepted beat for every masked channel, regardless of stall order.
  - Latency 0. Throughput 1 beat/cycle when all masked readies are high.
- REG_OUT=1 (buffered):
  - Per channel, a 2-entry FIFO with a 2-bit count (0..2), a 1-bit write pointer and a 1-bit read pointer.
  - a_ready = AND over i of (!a_mask[i] | count[i] < 2). It depends only on registered counts and a_mask, never on m_ready.
  - Push[i] = a_fire & a_mask[i]. Pop[i] = ch_fire[i].
  - m_valid[i] = (count[i] != 0). m_data[i] = entry at the read pointer. Both come from registers.
  - Latency: 1 cycle from a_fire to m_valid.
  - Full throughput, 1 beat/cycle, with all consumers ready.
  - Push and pop in the same cycle at count 1: count stays 1, FIFO order preserved.
  - Push at count 2 cannot occur (a_ready low).
  - Pop at count 0 cannot occur (m_valid low).
- Zero mask:
  - A beat with a_mask = 0 is accepted immediately (a_ready = 1) in both modes.
  - It produces no output valid and increments drop_cnt.
- Counters:
  - beat_cnt += 1 on every a_fire.
  - drop_cnt += 1 on a_fire & (a_mask == 0).
  - Both wrap from all-ones to 0 with no saturation.

Test Plan:
- REG_OUT=0, N_CH=4, DATA_WD=8: a_data=0x44332211, mask=4'b1111, all m_ready=1 -> same cycle m_data[0]=0x11 … m_data[3]=0x44, a_ready=1, beat_cnt=1.
- REG_OUT=0, mask=4'b0101, m_ready[0]=1, m_ready[2]=0 for 3 cycles, then 1:
  - Ch0 fires once, then m_valid[0]=0 (done[0]).
  - a_ready=0 for 3 cycles; a_fire in cycle 4.
  - Ch1 and ch3 never go valid.
- REG_OUT=1, 6 back-to-back beats 0x..01…0x..06, mask=4'b1111, m_ready[3]=0:
  - a_ready drops after beat 2.
  - Ch0..2 each drain beats 1..2 in order.
  - On releasing ch3, all 6 beats arrive in order on every channel with no loss or duplication.
- mask=4'b0000 with a_valid=1 for 3 cycles -> a_ready=1, no m_valid, beat_cnt=3, drop_cnt=3.
- CNT_WD=4: 17 accepted beats -> beat_cnt wraps 15→0, reads 1.
- Assert rst_n=0 while REG_OUT=1 buffers hold 2 entries and REG_OUT=0 has done[1]=1 -> next cycle m_valid=0, counts 0, counters 0. After release, a new beat is delivered normally.
